// File: rtl/rat_pkg.sv
// Shared types for the register alias table: per-register rename state.
package rat_pkg;

   // Per-register state. COMM: value lives in the committed file.
   // PEND: waiting on the producer tag. DONE: speculative value valid.
   typedef enum logic [1:0] {
      ST_COMM = 2'd0,
      ST_PEND = 2'd1,
      ST_DONE = 2'd2
   } rat_state_e;

endpackage

// File: rtl/rat_entry.sv
// One architectural register's alias entry: state, producer tag,
// speculative value and committed value.
// Same-cycle priority: flush > rename > retire > writeback.
module rat_entry
   import rat_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ROBW = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_flush,
   input  logic            i_ren_hit,
   input  logic [ROBW-1:0] i_ren_robid,
   input  logic            i_wb_hit,
   input  logic [ROBW-1:0] i_wb_robid,
   input  logic [XLEN-1:0] i_wb_result,
   input  logic            i_ret_hit,
   input  logic [ROBW-1:0] i_ret_robid,
   input  logic [XLEN-1:0] i_ret_result,
   output logic [1:0]      o_state,
   output logic [ROBW-1:0] o_tag,
   output logic [XLEN-1:0] o_spec,
   output logic [XLEN-1:0] o_comm
);

   rat_state_e      r_state;
   logic [ROBW-1:0] r_tag;
   logic [XLEN-1:0] r_spec;
   logic [XLEN-1:0] r_comm;

   // Entry update: committed write always lands, then the state priority chain.
   // NOTE: sequential state uses non-blocking (<=) so every entry samples
   // the pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk) begin
      // NOTE: these are individual flops, not a RAM, so resetting every
      // entry is cheap and gives a known COMM/zero starting point.
      if (rst) begin
         r_state <= ST_COMM;
         r_tag   <= '0;
         r_spec  <= '0;
         r_comm  <= '0;
      end else begin
         if (i_ret_hit)
            r_comm <= i_ret_result;

         if (i_flush) begin
            r_state <= ST_COMM;
         end else if (i_ren_hit) begin
            r_state <= ST_PEND;
            r_tag   <= i_ren_robid;
         end else if (i_ret_hit && r_state != ST_COMM && r_tag == i_ret_robid) begin
            r_state <= ST_COMM;
         end else if (i_wb_hit && r_state == ST_PEND && r_tag == i_wb_robid) begin
            r_state <= ST_DONE;
            r_spec  <= i_wb_result;
         end
      end
   end

   assign o_state = r_state;
   assign o_tag   = r_tag;
   assign o_spec  = r_spec;
   assign o_comm  = r_comm;

endmodule

// File: rtl/rat_mp.sv
// Multi-lane register alias table. Renames NLANE instructions per cycle,
// tracks youngest producer per register, and returns registered
// ready + value-or-tag for both sources of every lane.
module rat_mp
   import rat_pkg::*;
#(
   parameter  int NLANE = 2,
   parameter  int NREGS = 32,
   parameter  int XLEN  = 32,
   parameter  int ROBW  = 7,
   localparam int REGW  = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NLANE-1:0]      ren_valid,
   input  logic [NLANE-1:0]      ren_rd_en,
   input  logic [NLANE*REGW-1:0] ren_rd,
   input  logic [NLANE*ROBW-1:0] ren_robid,
   input  logic [NLANE*REGW-1:0] ren_rs1,
   input  logic [NLANE*REGW-1:0] ren_rs2,
   output logic [NLANE-1:0]      rat_out_valid,
   output logic [NLANE-1:0]      rat_rs1_ready,
   output logic [NLANE-1:0]      rat_rs2_ready,
   output logic [NLANE*XLEN-1:0] rat_rs1_tagval,
   output logic [NLANE*XLEN-1:0] rat_rs2_tagval,
   input  logic                  wb_valid,
   input  logic                  wb_error,
   input  logic [ROBW-1:0]       wb_robid,
   input  logic [REGW-1:0]       wb_rd,
   input  logic [XLEN-1:0]       wb_result,
   input  logic                  rob_ret_valid,
   input  logic [REGW-1:0]       rob_ret_rd,
   input  logic [ROBW-1:0]       rob_ret_robid,
   input  logic [XLEN-1:0]       rob_ret_result,
   input  logic                  rob_flush
);

   logic [1:0]      w_state [NREGS];
   logic [ROBW-1:0] w_tag   [NREGS];
   logic [XLEN-1:0] w_spec  [NREGS];
   logic [XLEN-1:0] w_comm  [NREGS];

   logic            w_ren_hit [NREGS];
   logic [ROBW-1:0] w_ren_id  [NREGS];

   logic [NLANE-1:0]      w_lk_rdy [2];
   logic [NLANE*XLEN-1:0] w_lk_val [2];

   logic [NLANE-1:0]      r_out_valid;
   logic [NLANE-1:0]      r_rdy [2];
   logic [NLANE*XLEN-1:0] r_val [2];

   // Collapse the rename group per register; ascending scan lets the highest lane win.
   // NOTE: every always_comb output gets a default first so no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         w_ren_hit[r] = 1'b0;
         w_ren_id[r]  = '0;
      end
      for (int l = 0; l < NLANE; l++) begin
         if (ren_valid[l] && ren_rd_en[l]) begin
            w_ren_hit[ren_rd[l*REGW +: REGW]] = 1'b1;
            w_ren_id[ren_rd[l*REGW +: REGW]]  = ren_robid[l*ROBW +: ROBW];
         end
      end
   end

   // Register 0 is hardwired zero and never renamed.
   assign w_state[0] = ST_COMM;
   assign w_tag[0]   = '0;
   assign w_spec[0]  = '0;
   assign w_comm[0]  = '0;

   for (genvar g = 1; g < NREGS; g++) begin : g_entry
      rat_entry #(
         .XLEN (XLEN),
         .ROBW (ROBW)
      ) u_entry (
         .clk          (clk),
         .rst          (rst),
         .i_flush      (rob_flush),
         .i_ren_hit    (w_ren_hit[g]),
         .i_ren_robid  (w_ren_id[g]),
         .i_wb_hit     (wb_valid && !wb_error && wb_rd == REGW'(g)),
         .i_wb_robid   (wb_robid),
         .i_wb_result  (wb_result),
         .i_ret_hit    (rob_ret_valid && rob_ret_rd == REGW'(g)),
         .i_ret_robid  (rob_ret_robid),
         .i_ret_result (rob_ret_result),
         .o_state      (w_state[g]),
         .o_tag        (w_tag[g]),
         .o_spec       (w_spec[g]),
         .o_comm       (w_comm[g])
      );
   end

   // Source lookup on pre-cycle state with intra-group and writeback/retire bypass.
   always_comb begin
      logic [REGW-1:0] v_src;
      logic            v_byp;
      logic [ROBW-1:0] v_byp_id;
      logic            v_rdy;
      logic [XLEN-1:0] v_val;
      for (int k = 0; k < 2; k++) begin
         w_lk_rdy[k] = '0;
         w_lk_val[k] = '0;
      end
      for (int i = 0; i < NLANE; i++) begin
         for (int k = 0; k < 2; k++) begin
            v_src    = (k == 0) ? ren_rs1[i*REGW +: REGW] : ren_rs2[i*REGW +: REGW];
            v_byp    = 1'b0;
            v_byp_id = '0;
            v_rdy    = 1'b1;
            v_val    = '0;
            for (int j = 0; j < NLANE; j++) begin
               if (j < i && ren_valid[j] && ren_rd_en[j] && ren_rd[j*REGW +: REGW] == v_src) begin
                  v_byp    = 1'b1;
                  v_byp_id = ren_robid[j*ROBW +: ROBW];
               end
            end
            if (v_src != '0) begin
               if (v_byp) begin
                  v_rdy = 1'b0;
                  v_val = XLEN'(v_byp_id);
               end else if (w_state[v_src] == ST_PEND) begin
                  if (wb_valid && !wb_error && wb_rd == v_src && wb_robid == w_tag[v_src]) begin
                     v_val = wb_result;
                  end else if (rob_ret_valid && rob_ret_rd == v_src && rob_ret_robid == w_tag[v_src]) begin
                     v_val = rob_ret_result;
                  end else begin
                     v_rdy = 1'b0;
                     v_val = XLEN'(w_tag[v_src]);
                  end
               end else if (w_state[v_src] == ST_DONE) begin
                  v_val = w_spec[v_src];
               end else begin
                  v_val = w_comm[v_src];
               end
            end
            w_lk_rdy[k][i]              = v_rdy;
            w_lk_val[k][i*XLEN +: XLEN] = v_val;
         end
      end
   end

   // Register lookup results; a flush drops the group's valid bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= '0;
         for (int k = 0; k < 2; k++) begin
            r_rdy[k] <= '0;
            r_val[k] <= '0;
         end
      end else begin
         r_out_valid <= rob_flush ? '0 : ren_valid;
         for (int k = 0; k < 2; k++) begin
            r_rdy[k] <= w_lk_rdy[k];
            r_val[k] <= w_lk_val[k];
         end
      end
   end

   assign rat_out_valid  = r_out_valid;
   assign rat_rs1_ready  = r_rdy[0];
   assign rat_rs2_ready  = r_rdy[1];
   assign rat_rs1_tagval = r_val[0];
   assign rat_rs2_tagval = r_val[1];

endmodule

// File: tb/tb_rat_mp.sv
// Self-checking bench for rat_mp: directed scenarios followed by random
// traffic, all checked against a behavioural register-alias model.
module tb_rat_mp;

   localparam int NLANE = 2;
   localparam int NREGS = 32;
   localparam int XLEN  = 32;
   localparam int ROBW  = 7;
   localparam int REGW  = 5;

   logic                  clk;
   logic                  rst;
   logic [NLANE-1:0]      ren_valid;
   logic [NLANE-1:0]      ren_rd_en;
   logic [NLANE*REGW-1:0] ren_rd;
   logic [NLANE*ROBW-1:0] ren_robid;
   logic [NLANE*REGW-1:0] ren_rs1;
   logic [NLANE*REGW-1:0] ren_rs2;
   logic [NLANE-1:0]      rat_out_valid;
   logic [NLANE-1:0]      rat_rs1_ready;
   logic [NLANE-1:0]      rat_rs2_ready;
   logic [NLANE*XLEN-1:0] rat_rs1_tagval;
   logic [NLANE*XLEN-1:0] rat_rs2_tagval;
   logic                  wb_valid;
   logic                  wb_error;
   logic [ROBW-1:0]       wb_robid;
   logic [REGW-1:0]       wb_rd;
   logic [XLEN-1:0]       wb_result;
   logic                  rob_ret_valid;
   logic [REGW-1:0]       rob_ret_rd;
   logic [ROBW-1:0]       rob_ret_robid;
   logic [XLEN-1:0]       rob_ret_result;
   logic                  rob_flush;

   rat_mp #(
      .NLANE (NLANE),
      .NREGS (NREGS),
      .XLEN  (XLEN),
      .ROBW  (ROBW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ren_valid      (ren_valid),
      .ren_rd_en      (ren_rd_en),
      .ren_rd         (ren_rd),
      .ren_robid      (ren_robid),
      .ren_rs1        (ren_rs1),
      .ren_rs2        (ren_rs2),
      .rat_out_valid  (rat_out_valid),
      .rat_rs1_ready  (rat_rs1_ready),
      .rat_rs2_ready  (rat_rs2_ready),
      .rat_rs1_tagval (rat_rs1_tagval),
      .rat_rs2_tagval (rat_rs2_tagval),
      .wb_valid       (wb_valid),
      .wb_error       (wb_error),
      .wb_robid       (wb_robid),
      .wb_rd          (wb_rd),
      .wb_result      (wb_result),
      .rob_ret_valid  (rob_ret_valid),
      .rob_ret_rd     (rob_ret_rd),
      .rob_ret_robid  (rob_ret_robid),
      .rob_ret_result (rob_ret_result),
      .rob_flush      (rob_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: per register, committed value, and whether a producer is
   // outstanding (m_busy) or its speculative result has arrived (m_fwd).
   logic [XLEN-1:0] m_comm [NREGS];
   logic [XLEN-1:0] m_spec [NREGS];
   logic [ROBW-1:0] m_tag  [NREGS];
   bit              m_busy [NREGS];
   bit              m_fwd  [NREGS];

   bit              e_valid [NLANE];
   bit              e_rdy   [2][NLANE];
   logic [XLEN-1:0] e_val   [2][NLANE];

   task automatic model_reset();
      for (int r = 0; r < NREGS; r++) begin
         m_comm[r] = '0;
         m_spec[r] = '0;
         m_tag[r]  = '0;
         m_busy[r] = 1'b0;
         m_fwd[r]  = 1'b0;
      end
   endtask

   task automatic model_lookup(input int i, input int s, output bit rdy, output logic [XLEN-1:0] v);
      rdy = 1'b1;
      v   = '0;
      if (s == 0) return;
      for (int j = i - 1; j >= 0; j--) begin
         if (ren_valid[j] && ren_rd_en[j] && int'(ren_rd[j*REGW +: REGW]) == s) begin
            rdy = 1'b0;
            v   = XLEN'(ren_robid[j*ROBW +: ROBW]);
            return;
         end
      end
      if (m_busy[s]) begin
         if (wb_valid && !wb_error && int'(wb_rd) == s && wb_robid == m_tag[s])
            v = wb_result;
         else if (rob_ret_valid && int'(rob_ret_rd) == s && rob_ret_robid == m_tag[s])
            v = rob_ret_result;
         else begin
            rdy = 1'b0;
            v   = XLEN'(m_tag[s]);
         end
      end else if (m_fwd[s]) begin
         v = m_spec[s];
      end else begin
         v = m_comm[s];
      end
   endtask

   task automatic model_update();
      bit              renamed [NREGS];
      logic [ROBW-1:0] newtag  [NREGS];
      int              rr;
      int              wr;
      bit              ret_moved;
      for (int r = 0; r < NREGS; r++) begin
         renamed[r] = 1'b0;
         newtag[r]  = '0;
      end
      rr = int'(rob_ret_rd);
      wr = int'(wb_rd);
      if (rob_flush) begin
         for (int r = 0; r < NREGS; r++) begin
            m_busy[r] = 1'b0;
            m_fwd[r]  = 1'b0;
         end
         if (rob_ret_valid && rr != 0) m_comm[rr] = rob_ret_result;
         return;
      end
      for (int l = 0; l < NLANE; l++) begin
         if (ren_valid[l] && ren_rd_en[l] && ren_rd[l*REGW +: REGW] != 0) begin
            renamed[int'(ren_rd[l*REGW +: REGW])] = 1'b1;
            newtag[int'(ren_rd[l*REGW +: REGW])]  = ren_robid[l*ROBW +: ROBW];
         end
      end
      ret_moved = 1'b0;
      if (rob_ret_valid && rr != 0) begin
         m_comm[rr] = rob_ret_result;
         if (!renamed[rr] && (m_busy[rr] || m_fwd[rr]) && m_tag[rr] == rob_ret_robid) begin
            m_busy[rr] = 1'b0;
            m_fwd[rr]  = 1'b0;
            ret_moved  = 1'b1;
         end
      end
      if (wb_valid && !wb_error && wr != 0 && !renamed[wr] && !(ret_moved && rr == wr)
          && m_busy[wr] && m_tag[wr] == wb_robid) begin
         m_busy[wr] = 1'b0;
         m_fwd[wr]  = 1'b1;
         m_spec[wr] = wb_result;
      end
      for (int r = 1; r < NREGS; r++) begin
         if (renamed[r]) begin
            m_busy[r] = 1'b1;
            m_fwd[r]  = 1'b0;
            m_tag[r]  = newtag[r];
         end
      end
   endtask

   task automatic clear_inputs();
      ren_valid      = '0;
      ren_rd_en      = '0;
      ren_rd         = '0;
      ren_robid      = '0;
      ren_rs1        = '0;
      ren_rs2        = '0;
      wb_valid       = 1'b0;
      wb_error       = 1'b0;
      wb_robid       = '0;
      wb_rd          = '0;
      wb_result      = '0;
      rob_ret_valid  = 1'b0;
      rob_ret_rd     = '0;
      rob_ret_robid  = '0;
      rob_ret_result = '0;
      rob_flush      = 1'b0;
   endtask

   task automatic begin_cycle();
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic set_lane(input int l, input bit rde, input int rd, input int id,
                           input int rs1, input int rs2);
      ren_valid[l]               = 1'b1;
      ren_rd_en[l]               = rde;
      ren_rd[l*REGW +: REGW]     = REGW'(rd);
      ren_robid[l*ROBW +: ROBW]  = ROBW'(id);
      ren_rs1[l*REGW +: REGW]    = REGW'(rs1);
      ren_rs2[l*REGW +: REGW]    = REGW'(rs2);
   endtask

   // Compute expectations from the model on pre-cycle state, advance the
   // model, clock the DUT and compare the registered outputs.
   task automatic step();
      for (int i = 0; i < NLANE; i++) begin
         e_valid[i] = ren_valid[i] && !rob_flush;
         model_lookup(i, int'(ren_rs1[i*REGW +: REGW]), e_rdy[0][i], e_val[0][i]);
         model_lookup(i, int'(ren_rs2[i*REGW +: REGW]), e_rdy[1][i], e_val[1][i]);
      end
      model_update();
      @(posedge clk);
      #1;
      for (int i = 0; i < NLANE; i++) begin
         check("out_valid", 64'(rat_out_valid[i]), 64'(e_valid[i]));
         if (e_valid[i]) begin
            check("rs1_ready", 64'(rat_rs1_ready[i]), 64'(e_rdy[0][i]));
            check("rs1_tagval", 64'(rat_rs1_tagval[i*XLEN +: XLEN]), 64'(e_val[0][i]));
            check("rs2_ready", 64'(rat_rs2_ready[i]), 64'(e_rdy[1][i]));
            check("rs2_tagval", 64'(rat_rs2_tagval[i*XLEN +: XLEN]), 64'(e_val[1][i]));
         end
      end
   endtask

   function automatic logic [XLEN-1:0] tv1(input int l);
      return rat_rs1_tagval[l*XLEN +: XLEN];
   endfunction

   function automatic logic [XLEN-1:0] tv2(input int l);
      return rat_rs2_tagval[l*XLEN +: XLEN];
   endfunction

   initial begin
      int r;
      clear_inputs();
      model_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(rat_out_valid), 64'd0);
      check("rst_ready", 64'({rat_rs1_ready, rat_rs2_ready}), 64'd0);
      check("rst_tagval1", 64'(rat_rs1_tagval), 64'd0);
      check("rst_tagval2", 64'(rat_rs2_tagval), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Plain lookup after reset.
      begin_cycle();
      set_lane(0, 1'b0, 0, 0, 5, 0);
      step();
      check("d_rst_rdy", 64'({rat_rs1_ready[0], rat_rs2_ready[0]}), 64'b11);
      check("d_rst_v1", 64'(tv1(0)), 64'd0);
      check("d_rst_v2", 64'(tv2(0)), 64'd0);

      // Intra-group bypass.
      begin_cycle();
      set_lane(0, 1'b1, 3, 'h12, 0, 0);
      set_lane(1, 1'b0, 0, 0, 3, 0);
      step();
      check("d_byp_rdy", 64'(rat_rs1_ready[1]), 64'd0);
      check("d_byp_tag", 64'(tv1(1)), 64'h12);

      // Writeback bypass, then DONE.
      begin_cycle();
      set_lane(0, 1'b0, 0, 0, 3, 0);
      wb_valid = 1'b1; wb_robid = 7'h12; wb_rd = 5'd3; wb_result = 32'hDEADBEEF;
      step();
      check("d_wbbyp_rdy", 64'(rat_rs1_ready[0]), 64'd1);
      check("d_wbbyp_val", 64'(tv1(0)), 64'hDEADBEEF);
      begin_cycle();
      set_lane(1, 1'b0, 0, 0, 0, 3);
      step();
      check("d_done_rdy", 64'(rat_rs2_ready[1]), 64'd1);
      check("d_done_val", 64'(tv2(1)), 64'hDEADBEEF);

      // Stale writeback and stale retire.
      begin_cycle();
      set_lane(0, 1'b1, 3, 'h12, 0, 0);
      step();
      begin_cycle();
      set_lane(0, 1'b1, 3, 'h20, 0, 0);
      step();
      begin_cycle();
      set_lane(0, 1'b0, 0, 0, 3, 0);
      wb_valid = 1'b1; wb_robid = 7'h12; wb_rd = 5'd3; wb_result = 32'h1111;
      step();
      check("d_stale_wb_rdy", 64'(rat_rs1_ready[0]), 64'd0);
      check("d_stale_wb_tag", 64'(tv1(0)), 64'h20);
      begin_cycle();
      rob_ret_valid = 1'b1; rob_ret_rd = 5'd3; rob_ret_robid = 7'h12; rob_ret_result = 32'd7;
      step();
      begin_cycle();
      set_lane(0, 1'b0, 0, 0, 3, 0);
      step();
      check("d_stale_ret_rdy", 64'(rat_rs1_ready[0]), 64'd0);
      check("d_stale_ret_tag", 64'(tv1(0)), 64'h20);

      // Renames in flight, retire x4, flush, then committed values.
      begin_cycle();
      set_lane(0, 1'b1, 4, 'h30, 0, 0);
      set_lane(1, 1'b1, 5, 'h31, 0, 0);
      step();
      begin_cycle();
      rob_ret_valid = 1'b1; rob_ret_rd = 5'd4; rob_ret_robid = 7'h05; rob_ret_result = 32'd9;
      step();
      begin_cycle();
      rob_flush = 1'b1;
      step();
      check("d_flush_valid", 64'(rat_out_valid), 64'd0);
      begin_cycle();
      set_lane(0, 1'b0, 0, 0, 4, 5);
      set_lane(1, 1'b0, 0, 0, 3, 6);
      step();
      check("d_fl_rdy", 64'({rat_rs1_ready, rat_rs2_ready}), 64'hF);
      check("d_fl_x4", 64'(tv1(0)), 64'd9);
      check("d_fl_x5", 64'(tv2(0)), 64'd0);
      check("d_fl_x3", 64'(tv1(1)), 64'd7);

      // Faulted writeback keeps PEND; x0 is never renamed.
      begin_cycle();
      set_lane(0, 1'b1, 6, 'h40, 0, 0);
      step();
      begin_cycle();
      wb_valid = 1'b1; wb_error = 1'b1; wb_robid = 7'h40; wb_rd = 5'd6; wb_result = 32'h55;
      step();
      begin_cycle();
      set_lane(0, 1'b0, 0, 0, 6, 0);
      step();
      check("d_err_rdy", 64'(rat_rs1_ready[0]), 64'd0);
      check("d_err_tag", 64'(tv1(0)), 64'h40);
      begin_cycle();
      set_lane(0, 1'b1, 0, 'h41, 0, 0);
      set_lane(1, 1'b0, 0, 0, 0, 0);
      rob_ret_valid = 1'b1; rob_ret_rd = 5'd0; rob_ret_result = 32'd55;
      step();
      check("d_x0_rdy", 64'(rat_rs1_ready[1]), 64'd1);
      check("d_x0_val", 64'(tv1(1)), 64'd0);
      begin_cycle();
      set_lane(0, 1'b0, 0, 0, 0, 0);
      step();
      check("d_x0_after", 64'(tv1(0)), 64'd0);

      // Random traffic over a small register window to force collisions.
      for (int c = 0; c < 3000; c++) begin
         begin_cycle();
         rob_flush = ($urandom_range(0, 49) == 0);
         if (!rob_flush) begin
            for (int l = 0; l < NLANE; l++) begin
               if ($urandom_range(0, 3) != 0)
                  set_lane(l, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                           $urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 7));
            end
         end
         if ($urandom_range(0, 9) < 7) begin
            r         = $urandom_range(0, 7);
            wb_valid  = 1'b1;
            wb_error  = ($urandom_range(0, 7) == 0);
            wb_rd     = REGW'(r);
            wb_robid  = ((m_busy[r] || m_fwd[r]) && $urandom_range(0, 3) != 0) ? m_tag[r]
                        : ROBW'($urandom_range(0, 127));
            wb_result = $urandom;
         end
         if ($urandom_range(0, 9) < 4) begin
            r              = $urandom_range(0, 7);
            rob_ret_valid  = 1'b1;
            rob_ret_rd     = REGW'(r);
            rob_ret_robid  = ($urandom_range(0, 1) == 1) ? m_tag[r] : ROBW'($urandom_range(0, 127));
            rob_ret_result = $urandom;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
